// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out deserializer family:
// bit-order selectors and width helpers used to size counters and ports.
package sipo_pkg;

  localparam bit SIPO_MSB_FIRST = 1'b1;
  localparam bit SIPO_LSB_FIRST = 1'b0;

  // Bits needed to hold any value in 0..value-1.
  function automatic int sipo_clog2(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  // Bits needed for a bit counter that reports 0..width (at least one bit).
  function automatic int sipo_count_width(input int width);
    return sipo_clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Modulo-WIDTH bit counter that frames serial words. It flags the increment
// that completes a word, so the caller can act on it in the same cycle.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = sipo_count_width(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_count;

  // Count accepted bits; clear wins over increment, and the last bit of a
  // word returns the count to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= (r_count == LAST) ? '0 : r_count + ONE;
    end
  end

  assign count = r_count;
  assign wrap  = inc && (r_count == LAST);

endmodule

// File: rtl/sipo_deserializer.sv
// Parametrised serial-in/parallel-out deserializer. Bits are shifted in under
// a per-bit qualifier, words are framed by a bit counter, and each finished
// word is parked in a ready/valid holding register with sticky overrun.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = SIPO_MSB_FIRST
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 serial_in,
  input  logic                                 serial_valid,
  input  logic                                 clear,
  output logic [WIDTH-1:0]                     shift_out,
  output logic [sipo_count_width(WIDTH)-1:0]   bit_count,
  output logic [WIDTH-1:0]                     parallel_out,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 overrun
);

  localparam int CW = sipo_count_width(WIDTH);

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_parallel;
  logic             r_valid;
  logic             r_overrun;

  logic [WIDTH-1:0] w_nextShift;
  logic [CW-1:0]    w_count;
  logic             w_accept;
  logic             w_complete;
  logic             w_transfer;
  logic             w_slotFree;

  // A bit is taken only when qualified and no resync is requested.
  assign w_accept   = serial_valid && !clear;
  assign w_transfer = r_valid && out_ready;
  assign w_slotFree = !r_valid || out_ready;

  sipo_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bitCounter (
    .clk   (clk),
    .reset (reset),
    .inc   (w_accept),
    .clr   (clear),
    .count (w_count),
    .wrap  (w_complete)
  );

  // Bit order only changes which end of the register the new bit enters.
  generate
    if (MSB_FIRST) begin : g_msbFirst
      assign w_nextShift = {r_shift[WIDTH-2:0], serial_in};
    end else begin : g_lsbFirst
      assign w_nextShift = {serial_in, r_shift[WIDTH-1:1]};
    end
  endgenerate

  // Shift register: cleared by resync, advanced by accepted bits, and left
  // showing the assembled word after completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
    end else if (clear) begin
      r_shift <= '0;
    end else if (serial_valid) begin
      r_shift <= w_nextShift;
    end
  end

  // Holding register and handshake: a finished word loads when the slot is
  // empty or being drained this edge; otherwise it is dropped and flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_parallel <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_complete && w_slotFree) begin
        r_parallel <= w_nextShift;
        r_valid    <= 1'b1;
      end else if (w_transfer) begin
        r_valid    <= 1'b0;
      end
      if (w_complete && !w_slotFree) begin
        r_overrun  <= 1'b1;
      end
    end
  end

  assign shift_out    = r_shift;
  assign bit_count    = w_count;
  assign parallel_out = r_parallel;
  assign out_valid    = r_valid;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: one MSB-first and one LSB-first
// instance share all inputs, so each bit sequence exercises both orders.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       serialIn;
  logic       serialValid;
  logic       clear;
  logic       outReady;

  logic [7:0] msbShift, msbParallel, lsbShift, lsbParallel;
  logic [3:0] msbCount, lsbCount;
  logic       msbValid, msbOverrun, lsbValid, lsbOverrun;

  int total = 0;
  int bad   = 0;

  // Free-running clock shared by both instances.
  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serialIn),
    .serial_valid (serialValid),
    .clear        (clear),
    .shift_out    (msbShift),
    .bit_count    (msbCount),
    .parallel_out (msbParallel),
    .out_valid    (msbValid),
    .out_ready    (outReady),
    .overrun      (msbOverrun)
  );

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serialIn),
    .serial_valid (serialValid),
    .clear        (clear),
    .shift_out    (lsbShift),
    .bit_count    (lsbCount),
    .parallel_out (lsbParallel),
    .out_valid    (lsbValid),
    .out_ready    (outReady),
    .overrun      (lsbOverrun)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", tag, observed, expected);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic bitVal);
    serialIn    = bitVal;
    serialValid = 1'b1;
    tick();
    serialValid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    serialValid = 1'b0;
    repeat (n) tick();
  endtask

  // Sends seq[7] first down to seq[0] last.
  task automatic sendSeq(input logic [7:0] seq);
    for (int i = 7; i >= 0; i--) applyStimulus(seq[i]);
  endtask

  initial begin
    reset = 1'b1; serialIn = 1'b0; serialValid = 1'b0; clear = 1'b0; outReady = 1'b0;
    tick(); tick();
    reset = 1'b0;
    checkOutput("rst_shift",   msbShift,    8'h00);
    checkOutput("rst_count",   msbCount,    4'd0);
    checkOutput("rst_par",     msbParallel, 8'h00);
    checkOutput("rst_valid",   msbValid,    1'b0);
    checkOutput("rst_overrun", msbOverrun,  1'b0);

    // MSB-first word, consumer always ready.
    outReady = 1'b1;
    for (int i = 7; i >= 1; i--) applyStimulus(logic'(8'hB2 >> i));
    checkOutput("t1_count7",   msbCount,    4'd7);
    checkOutput("t1_valid_pre", msbValid,   1'b0);
    applyStimulus(1'b0);
    checkOutput("t1_msb_par",  msbParallel, 8'hB2);
    checkOutput("t1_lsb_par",  lsbParallel, 8'h4D);
    checkOutput("t1_valid",    msbValid,    1'b1);
    checkOutput("t1_count0",   msbCount,    4'd0);
    checkOutput("t1_shift",    msbShift,    8'hB2);
    idleCycles(1);
    checkOutput("t1_valid_drop", msbValid,  1'b0);
    checkOutput("t1_par_hold", msbParallel, 8'hB2);

    // LSB-first with gaps after bits 2 and 5, starting from a resynced frame.
    clear = 1'b1; tick(); clear = 1'b0;
    checkOutput("t2_clr_shift", lsbShift, 8'h00);
    applyStimulus(1'b1); applyStimulus(1'b0);
    idleCycles(3);
    checkOutput("t2_gap1_shift", lsbShift, 8'h40);
    checkOutput("t2_gap1_count", lsbCount, 4'd2);
    applyStimulus(1'b1); applyStimulus(1'b1); applyStimulus(1'b0);
    idleCycles(3);
    checkOutput("t2_gap2_shift", lsbShift, 8'h68);
    checkOutput("t2_gap2_count", lsbCount, 4'd5);
    applyStimulus(1'b0); applyStimulus(1'b1); applyStimulus(1'b0);
    checkOutput("t2_lsb_par",  lsbParallel, 8'h4D);
    checkOutput("t2_msb_par",  msbParallel, 8'hB2);
    checkOutput("t2_valid",    lsbValid,    1'b1);
    checkOutput("t2_count0",   lsbCount,    4'd0);
    idleCycles(1);

    // Backpressure and overrun.
    outReady = 1'b0;
    sendSeq(8'hB2);
    checkOutput("t3_valid1",   msbValid,    1'b1);
    checkOutput("t3_no_ovr",   msbOverrun,  1'b0);
    sendSeq(8'hFF);
    checkOutput("t3_par_keep", msbParallel, 8'hB2);
    checkOutput("t3_lsb_keep", lsbParallel, 8'h4D);
    checkOutput("t3_valid2",   msbValid,    1'b1);
    checkOutput("t3_overrun",  msbOverrun,  1'b1);
    checkOutput("t3_lsb_ovr",  lsbOverrun,  1'b1);
    checkOutput("t3_shift_ff", msbShift,    8'hFF);
    outReady = 1'b1; tick(); outReady = 1'b0;
    checkOutput("t3_valid_drop", msbValid,  1'b0);
    checkOutput("t3_ovr_sticky", msbOverrun, 1'b1);
    checkOutput("t3_par_hold", msbParallel, 8'hB2);

    // Simultaneous completion and transfer after a fresh reset.
    reset = 1'b1; tick(); reset = 1'b0;
    checkOutput("t4_rst_ovr",  msbOverrun,  1'b0);
    sendSeq(8'h0F);
    checkOutput("t4_a_par",    msbParallel, 8'h0F);
    checkOutput("t4_a_valid",  msbValid,    1'b1);
    for (int i = 7; i >= 1; i--) applyStimulus(logic'(8'hF0 >> i));
    outReady = 1'b1;
    applyStimulus(1'b0);
    outReady = 1'b0;
    checkOutput("t4_b_par",    msbParallel, 8'hF0);
    checkOutput("t4_b_lsb",    lsbParallel, 8'h0F);
    checkOutput("t4_b_valid",  msbValid,    1'b1);
    checkOutput("t4_b_ovr",    msbOverrun,  1'b0);

    // Clear mid-word, with a pending word and a bit offered in the clear cycle.
    applyStimulus(1'b1); applyStimulus(1'b0); applyStimulus(1'b1);
    checkOutput("t5_count3",   msbCount,    4'd3);
    clear = 1'b1; serialIn = 1'b1; serialValid = 1'b1;
    tick();
    clear = 1'b0; serialValid = 1'b0;
    checkOutput("t5_clr_count", msbCount,   4'd0);
    checkOutput("t5_clr_shift", msbShift,   8'h00);
    checkOutput("t5_clr_valid", msbValid,   1'b1);
    checkOutput("t5_clr_par",  msbParallel, 8'hF0);
    outReady = 1'b1;
    sendSeq(8'hF0);
    outReady = 1'b0;
    checkOutput("t5_shift",    msbShift,    8'hF0);
    checkOutput("t5_lsb_shift", lsbShift,   8'h0F);
    checkOutput("t5_par",      msbParallel, 8'hF0);
    checkOutput("t5_valid",    msbValid,    1'b1);
    checkOutput("t5_ovr",      msbOverrun,  1'b0);

    // Reset mid-word with a pending word and overrun set.
    sendSeq(8'h3C);
    checkOutput("t6_pre_ovr",  msbOverrun,  1'b1);
    applyStimulus(1'b1); applyStimulus(1'b1);
    reset = 1'b1; serialIn = 1'b1; serialValid = 1'b1; outReady = 1'b1;
    tick();
    reset = 1'b0; serialValid = 1'b0; outReady = 1'b0;
    checkOutput("t6_shift",    msbShift,    8'h00);
    checkOutput("t6_count",    msbCount,    4'd0);
    checkOutput("t6_par",      msbParallel, 8'h00);
    checkOutput("t6_valid",    msbValid,    1'b0);
    checkOutput("t6_ovr",      msbOverrun,  1'b0);
    checkOutput("t6_lsb_shift", lsbShift,   8'h00);
    sendSeq(8'h6C);
    checkOutput("t6_new_msb",  msbParallel, 8'h6C);
    checkOutput("t6_new_lsb",  lsbParallel, 8'h36);
    checkOutput("t6_new_valid", msbValid,   1'b1);
    checkOutput("t6_new_ovr",  msbOverrun,  1'b0);
    checkOutput("t6_new_count", msbCount,   4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

- Parametrised serial-in/parallel-out deserializer: successor to the fixed 4-bit SIPO shift register.
- Adds configurable word width and bit order, a per-bit qualifier, and a bit counter that frames words.
- Each completed word is handed off through a ready/valid output register with overrun detection.
- Sits between a serial receive front-end (SPI-like or UART bit stream) and word-wide consumer logic.

## Interface
- `WIDTH`, default 8: bits per word; legal range ≥ 2.
- `MSB_FIRST`, default 1: 1 means the first received bit lands in `parallel_out[WIDTH-1]`; 0 means the first bit lands in `parallel_out[0]`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `serial_in`  in  1  serial data bit; sampled only when `serial_valid`=1.
- `serial_valid`  in  1  qualifies `serial_in` this cycle.
- `clear`  in  1  synchronous frame resync; discards the partial word.
- `shift_out`  out  WIDTH  live shift-register contents.
- `bit_count`  out  $clog2(WIDTH+1)  bits accepted in the current word, 0..WIDTH-1.
- `parallel_out`  out  WIDTH  completed word (holding register).
- `out_valid`  out  1  `parallel_out` holds an unconsumed word.
- `out_ready`  in  1  consumer accepts the word.
- `overrun`  out  1  sticky: a completed word was dropped.

## Operation
- **Reset:** `reset`=1 clears `shift_out`, `bit_count`, `parallel_out`, `out_valid` and `overrun` to 0. Reset overrides every other input.
- **Accepting a bit** (`serial_valid`=1, `clear`=0):
  - `MSB_FIRST`=1: shift_out ← {shift_out[WIDTH-2:0], serial_in}.
  - `MSB_FIRST`=0: shift_out ← {serial_in, shift_out[WIDTH-1:1]}.
  - `bit_count` increments.
- **Idle:** with `serial_valid`=0, `shift_out` and `bit_count` hold.
- **Word completion:** the bit accepted while `bit_count`==WIDTH-1 completes the word.
  - `bit_count` wraps to 0.
  - The assembled word, including that bit, is the completed word.
  - `shift_out` also shows the assembled word; it is not cleared.
- **Output handshake:**
  - A transfer occurs on an edge where `out_valid`=1 and `out_ready`=1.
  - After a transfer with no new completion, `out_valid` goes to 0 and `parallel_out` holds its old value.
- **Completion when the holding register is free** (`out_valid`=0, or a transfer in the same cycle): `parallel_out` ← completed word and `out_valid`=1. A simultaneous completion and transfer therefore keeps `out_valid` at 1 with the new word.
- **Completion when the holding register is full** (`out_valid`=1, `out_ready`=0): the new word is dropped. `parallel_out` and `out_valid` are unchanged, and `overrun` sets to 1. It stays set until `reset`.
- **`clear`=1:**
  - `shift_out` and `bit_count` go to 0, and any `serial_valid` bit that cycle is discarded.
  - `parallel_out`, `out_valid` and `overrun` are unaffected; a handshake in the same cycle still completes.
- **Priority:** reset > clear > serial_valid.
- **`out_ready`** has no effect while `out_valid`=0.

## Timing
- One bit per cycle maximum; back-to-back `serial_valid` is supported at full rate.
- **Latency:** the WIDTH-th bit is sampled on edge N; `parallel_out` and `out_valid` are valid after edge N, in the same cycle `bit_count` reads 0.
- **Transfer:** the consumer samples `parallel_out` on the handshake edge; `out_valid` deasserts after that edge unless a new word completes on it.
- **Registered outputs:** all outputs come straight from registers, with no combinational path from inputs to outputs.
- **Gaps in `serial_valid`:** any gap length is allowed mid-word; framing is preserved.
- **Reset mid-word:** asserting reset mid-word loses the partial word and any pending output. The first bit after reset deasserts is bit 0 of a new word.

## Structure
- **Shared package `sipo_pkg`:** holds `function automatic clog2`-based width helpers, and the bit-order constants `SIPO_MSB_FIRST`=1 and `SIPO_LSB_FIRST`=0.
- **Sub-module `sipo_bit_counter`:** parametrised modulo-WIDTH counter with inputs `inc` and `clr`, outputs `count` and `wrap` (wrap = inc && count==WIDTH-1).
- **Top level:** shift register, holding register, handshake and overrun logic.

## Test plan
1. **MSB-first word:** WIDTH=8, `MSB_FIRST`=1, `out_ready`=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles → after the 8th edge `parallel_out`=8'hB2, `out_valid`=1 for exactly one cycle, and `bit_count` returns to 0.
2. **LSB-first with gaps:** `MSB_FIRST`=0, same bit sequence with `serial_valid` gaps of 3 cycles inserted after bits 2 and 5 → `parallel_out`=8'h4D; `shift_out` and `bit_count` hold during the gaps.
3. **Backpressure and overrun:** `out_ready`=0, send 8'hB2 then 8'hFF → `parallel_out` stays 8'hB2, `out_valid`=1, `overrun`=1. Raising `out_ready` for one cycle then drops `out_valid` to 0, while `overrun` stays 1.
4. **Simultaneous completion and transfer:** word A=8'h0F pending with `out_valid`=1; word B=8'hF0 completes on the same edge that `out_ready`=1 → `parallel_out`=8'hF0, `out_valid` stays 1, `overrun`=0.
5. **Clear mid-word:** 3 bits in, then `clear`=1 together with `serial_valid`=1 → `bit_count`=0 and `shift_out`=0, and that bit is ignored. The next 8 bits 1,1,1,1,0,0,0,0 give 8'hF0, and a pending `out_valid` is unaffected by the clear.
6. **Reset:** reset mid-word with `out_valid`=1 and `overrun`=1 → all outputs are 0 after the reset edge. The next 8 bits form a fresh, correct word.
